// File: rtl/mips_pkg.sv
// Shared MIPS core types: datapath widths, ALU opcodes, forward selects and ID/EX field bundles.
package mips_pkg;
    localparam int DW = 32;
    localparam int RW = 5;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_BEQ  = 4'b1001,
        ALU_BNE  = 4'b1010,
        ALU_NOR  = 4'b1100,
        ALU_ORI  = 4'b1101,
        ALU_XORI = 4'b1110,
        ALU_ANDI = 4'b1111
    } alu_op_e;

    // 2'b11 is reserved and decodes like FWD_REG
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_RSV = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       reg_dst;
        logic       alu_src;
        logic       shift_src;
        logic [3:0] alu_ctrl;
    } ex_ctrl_t;

    typedef struct packed {
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [4:0]    shamt;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc_plus4;
    } ex_data_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, hazard/forwarding controls and execute-side outputs of the ID/EX stage.
interface id_ex_stage_if;
    import mips_pkg::*;

    logic          StallE, FlushE;
    logic [DW-1:0] RD1D, RD2D, SignImmD, PCPlus4D;
    logic [4:0]    ShamtD;
    logic [RW-1:0] RsD, RtD, RdD;
    logic [3:0]    ALUControlD;
    logic          ALUSrcD, ShiftSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD, BranchD;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [DW-1:0] ALUOutM, ResultW;

    logic [DW-1:0] SrcAE, SrcBE, WriteDataE, PCPlus4E;
    logic [3:0]    ALUControlE;
    logic [RW-1:0] WriteRegE, RsE, RtE;
    logic          RegWriteE, MemtoRegE, MemWriteE, BranchE, ValidE;

    modport master (
        output StallE, FlushE, RD1D, RD2D, SignImmD, PCPlus4D, ShamtD, RsD, RtD, RdD,
               ALUControlD, ALUSrcD, ShiftSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD,
               BranchD, ForwardAE, ForwardBE, ALUOutM, ResultW,
        input  SrcAE, SrcBE, WriteDataE, PCPlus4E, ALUControlE, WriteRegE, RsE, RtE,
               RegWriteE, MemtoRegE, MemWriteE, BranchE, ValidE
    );

    modport slave (
        input  StallE, FlushE, RD1D, RD2D, SignImmD, PCPlus4D, ShamtD, RsD, RtD, RdD,
               ALUControlD, ALUSrcD, ShiftSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD,
               BranchD, ForwardAE, ForwardBE, ALUOutM, ResultW,
        output SrcAE, SrcBE, WriteDataE, PCPlus4E, ALUControlE, WriteRegE, RsE, RtE,
               RegWriteE, MemtoRegE, MemWriteE, BranchE, ValidE
    );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Forward select (registered / WB / MEM) with register $0 forced to zero; purely combinational.
// Macro ID_EX_FORWARD_EN enables the bypass inputs; otherwise only the registered value is used.
module fwd_mux
    import mips_pkg::*;
(
    input  logic [1:0]    sel_i,
    input  logic [RW-1:0] idx_i,
    input  logic [DW-1:0] reg_i,
    input  logic [DW-1:0] alu_out_m_i,
    input  logic [DW-1:0] result_w_i,
    output logic [DW-1:0] val_o
);
    logic [DW-1:0] sel_val;

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        sel_val = reg_i;
        case (fwd_sel_e'(sel_i))
            FWD_WB:  sel_val = result_w_i;
            FWD_MEM: sel_val = alu_out_m_i;
            default: sel_val = reg_i;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{sel_i, alu_out_m_i, result_w_i};
    assign sel_val    = reg_i;
`endif

    // $0 is hardwired zero even if a bypass source claims to write it
    assign val_o = (idx_i == '0) ? '0 : sel_val;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus execute-operand select; one cycle D->E, forwarding combinational.
// Flush beats stall beats load; macro ID_EX_FORWARD_EN enables MEM/WB bypass in fwd_mux.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic         CLK,
    input  logic         RST_N,
    id_ex_stage_if.slave bus
);
    ex_ctrl_t ctrl_q, ctrl_d;
    ex_data_t data_q, data_d;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (bus.FlushE) begin
            ctrl_d = '0;
            data_d = '0;
        end else if (!bus.StallE) begin
            ctrl_d.valid      = 1'b1;
            ctrl_d.reg_write  = bus.RegWriteD;
            ctrl_d.mem_to_reg = bus.MemtoRegD;
            ctrl_d.mem_write  = bus.MemWriteD;
            ctrl_d.branch     = bus.BranchD;
            ctrl_d.reg_dst    = bus.RegDstD;
            ctrl_d.alu_src    = bus.ALUSrcD;
            ctrl_d.shift_src  = bus.ShiftSrcD;
            ctrl_d.alu_ctrl   = bus.ALUControlD;
            data_d.rs         = bus.RsD;
            data_d.rt         = bus.RtD;
            data_d.rd         = bus.RdD;
            data_d.shamt      = bus.ShamtD;
            data_d.rd1        = bus.RD1D;
            data_d.rd2        = bus.RD2D;
            data_d.imm        = bus.SignImmD;
            data_d.pc_plus4   = bus.PCPlus4D;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    logic [DW-1:0] fwd_a, fwd_b;

    fwd_mux u_fwd_a (
        .sel_i       (bus.ForwardAE),
        .idx_i       (data_q.rs),
        .reg_i       (data_q.rd1),
        .alu_out_m_i (bus.ALUOutM),
        .result_w_i  (bus.ResultW),
        .val_o       (fwd_a)
    );

    fwd_mux u_fwd_b (
        .sel_i       (bus.ForwardBE),
        .idx_i       (data_q.rt),
        .reg_i       (data_q.rd2),
        .alu_out_m_i (bus.ALUOutM),
        .result_w_i  (bus.ResultW),
        .val_o       (fwd_b)
    );

    // Shifts carry the amount on A and the value to shift on B
    assign bus.SrcAE       = ctrl_q.shift_src ? {{(DW-5){1'b0}}, data_q.shamt} : fwd_a;
    assign bus.SrcBE       = ctrl_q.alu_src ? data_q.imm : fwd_b;
    assign bus.WriteDataE  = fwd_b;
    assign bus.WriteRegE   = ctrl_q.reg_dst ? data_q.rd : data_q.rt;
    assign bus.RsE         = data_q.rs;
    assign bus.RtE         = data_q.rt;
    assign bus.ALUControlE = ctrl_q.alu_ctrl;
    assign bus.RegWriteE   = ctrl_q.reg_write;
    assign bus.MemtoRegE   = ctrl_q.mem_to_reg;
    assign bus.MemWriteE   = ctrl_q.mem_write;
    assign bus.BranchE     = ctrl_q.branch;
    assign bus.PCPlus4E    = data_q.pc_plus4;
    assign bus.ValidE      = ctrl_q.valid;
endmodule
